// File: rtl/cycle_step_ctrl.sv
// Step-rate, pause and direction controller for the seven-segment clockwise animation.
// Latency: clean raw press to state change is DB_CYCLES+3 cycles; step is a registered one-cycle pulse.
// Backpressure: none, free-running pulse source. CYCLE_AUTO_REVERSE_EN adds a lap counter that reverses dir every 8 steps.
module cycle_step_ctrl #(
    parameter int BASE_DIV   = 3_125_000,
    parameter int DB_CYCLES  = 1_000_000,
    parameter int INIT_SPEED = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_faster,
    input  logic       btn_slower,
    input  logic       btn_pause,
    input  logic       btn_dir,
    output logic       step,
    output logic       dir,
    output logic       run,
    output logic [2:0] speed
);
    localparam int DBW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

    logic [3:0]     btn_raw;
    logic [3:0]     sync1, sync2, db, db_q, ev;
    logic [DBW-1:0] db_cnt [4];
    logic [31:0]    count;
    logic [31:0]    period;
    logic [2:0]     speed_nxt;
    logic           speed_chg;
    logic           wrap;

    // Bit order: 0 faster, 1 slower, 2 pause, 3 dir.
    assign btn_raw = {btn_dir, btn_pause, btn_slower, btn_faster};
    assign ev      = db & ~db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Opposing speed events cancel; saturated events leave speed_chg low so the phase is kept.
    always_comb begin
        speed_nxt = speed;
        if (ev[0] && !ev[1] && speed != 3'd7)
            speed_nxt = speed + 3'd1;
        else if (ev[1] && !ev[0] && speed != 3'd0)
            speed_nxt = speed - 3'd1;
    end

    assign speed_chg = (speed_nxt != speed);
    assign period    = 32'(BASE_DIV) << (3'd7 - speed);
    assign wrap      = run && !speed_chg && (count == period - 32'd1);

`ifdef CYCLE_AUTO_REVERSE_EN
    logic [2:0] lap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            step  <= 1'b0;
            run   <= 1'b1;
            dir   <= 1'b1;
            speed <= 3'(INIT_SPEED);
`ifdef CYCLE_AUTO_REVERSE_EN
            lap   <= '0;
`endif
        end else begin
            speed <= speed_nxt;
            step  <= wrap;
            if (speed_chg)
                count <= '0;
            else if (run)
                count <= wrap ? 32'd0 : count + 32'd1;
            // The pause event's own cycle still runs, so a coinciding step is issued.
            if (ev[2])
                run <= ~run;
`ifdef CYCLE_AUTO_REVERSE_EN
            if (ev[3]) begin
                dir <= ~dir;
                lap <= '0;
            end else if (wrap) begin
                lap <= lap + 3'd1;
                if (lap == 3'd7)
                    dir <= ~dir;
            end
`else
            if (ev[3])
                dir <= ~dir;
`endif
        end
    end
endmodule

// File: doc/cycle_step_ctrl.md
Name: cycle_step_ctrl

Overview:
- Upstream control stage for the seven-segment clockwise animation.
- Produces a one-cycle `step` enable pulse at a user-selectable rate, a direction level, and a run level; these drive the animation counter's enable and up/down inputs.
- Four raw board buttons (faster, slower, pause, direction) are synchronised, debounced and edge-detected internally.
- Speed, pause and direction state are held in this block.

Parameters:
- BASE_DIV, 3_125_000: prescaler period in clk cycles at the fastest speed level (7). Must be >= 2.
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change. Must be >= 1.
- INIT_SPEED, 3: speed level loaded at reset, range 0..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_faster  in  1  raw button, increase speed
- btn_slower  in  1  raw button, decrease speed
- btn_pause  in  1  raw button, toggle run/pause
- btn_dir  in  1  raw button, toggle direction
- step  out  1  one-cycle step pulse to the animation counter
- dir  out  1  1 = clockwise (count up), 0 = counter-clockwise
- run  out  1  1 = running, 0 = paused
- speed  out  3  current speed level, 0 = slowest, 7 = fastest

Behaviour:
- Reset (async assert, sync release) sets:
  - step=0, dir=1, run=1, speed=INIT_SPEED.
  - Prescaler count = 0.
  - All synchroniser, debounce and edge flops = 0.
- Button path, per button:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level updates only after the synchronised input has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a one-cycle internal pulse on a debounced 0->1 transition. Releases generate nothing.
  - Latency from a clean raw press to the resulting state change: DB_CYCLES+3 cycles.
- Speed:
  - A faster event increments `speed`, saturating at 7.
  - A slower event decrements `speed`, saturating at 0.
  - Faster and slower events in the same cycle: both ignored, speed unchanged.
- Period: P = BASE_DIV << (7 - speed) cycles. The prescaler count is 32 bits; the default worst case of 400,000,000 fits.
- Prescaler while run=1:
  - Increments each cycle.
  - When count == P-1: `step`=1 for that cycle and count wraps to 0.
  - The first step after reset is asserted in cycle P (1-based) after reset release.
- Prescaler while run=0: count holds and `step`=0. On resume, counting continues from the held value.
- Speed change (any event that actually modifies `speed`):
  - Count clears to 0 in that cycle.
  - `step` is suppressed in that cycle, even if count == P-1.
  - A saturated, no-op event does not clear the count.
- Pause event: toggles `run` at the next edge.
  - If a step would coincide with the pause event's cycle, the step is still issued; the pause takes effect from the following cycle.
- Direction event: toggles `dir`. This does not affect prescaler phase.
- `step` is registered (flop output) and never high for two consecutive cycles, since P >= 2.
- Reset asserted mid-period: all state returns to reset values immediately, with no trailing step pulse.

Optional Feature:
- Macro: CYCLE_AUTO_REVERSE_EN.
- When defined:
  - A 3-bit lap counter increments on each issued step.
  - On the step that wraps it from 7 to 0 (every 8th step, one full lap), `dir` toggles at the same edge the pulse is registered.
  - A direction button event toggles `dir` and clears the lap counter to 0.
  - Reset clears the lap counter to 0.
  - If the button event and lap wrap fall on the same cycle, the button wins: single toggle, lap counter 0.
- When undefined: no lap counter; `dir` changes only via btn_dir.

Test Plan:
- Overrides for all tests: BASE_DIV=2, DB_CYCLES=4.
- Reset period: release rst_n with no buttons pressed.
  - Required: speed=3, P=32.
  - `step` pulses at cycles 32, 64, 96 after release; dir=1, run=1 throughout.
- Speed saturation: 5 clean faster presses (held >= 8 cycles each, 20 cycles apart).
  - Required: speed goes 4,5,6,7,7; final P=2, step every 2nd cycle.
  - Then 8 slower presses -> speed=0, P=256.
- Debounce: btn_pause toggled every 2 cycles for 20 cycles, then held high.
  - Required: exactly one run toggle, 7 cycles after the final stable high.
  - Releasing the button generates no event.
- Pause/resume: pause at prescaler count 10 (speed 3), hold 100 cycles, resume.
  - Required: no step while run=0.
  - Next step occurs exactly 21 running cycles after resume.
- Simultaneous events: faster and slower debounced on the same cycle.
  - Required: speed unchanged, count not cleared.
  - A faster press at count 31 -> count cleared, no step that cycle.
- With CYCLE_AUTO_REVERSE_EN defined, speed=7:
  - Required: dir flips 1->0 on the 8th step and back to 1 on the 16th.
  - A btn_dir press after step 3 flips dir; the next auto flip follows 8 steps later.
